// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential 8x8 vedic multiplier controller.
package vedic_pkg;

    localparam int unsigned OPW  = 8;
    localparam int unsigned PRW  = 16;
    localparam int unsigned NIBW = 4;

    // Left shift applied to each nibble partial product, indexed by step
    localparam int unsigned SH0 = 0;
    localparam int unsigned SH1 = 4;
    localparam int unsigned SH2 = 4;
    localparam int unsigned SH3 = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } operand_t;

endpackage

// File: rtl/vedicmultiplier_4bit.sv
// Combinational 4x4 unsigned vedic multiplier built from four 2x2 vedic cells.
module vedicmultiplier_4bit #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH/2-1:0] a,
    input  logic [DATA_WIDTH/2-1:0] b,
    output logic [DATA_WIDTH-1:0]   c
);

    // Urdhva-tiryagbhyam 2x2 cell: vertical and crosswise partial bits
    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, t3, k1;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        t3 = x[1] & y[1];
        k1 = t1 & t2;
        return {t3 & k1, t3 ^ k1, t1 ^ t2, x[0] & y[0]};
    endfunction

    logic [3:0] q0, q1, q2, q3;

    always_comb begin
        q0 = vm2(a[1:0], b[1:0]);
        q1 = vm2(a[3:2], b[1:0]);
        q2 = vm2(a[1:0], b[3:2]);
        q3 = vm2(a[3:2], b[3:2]);
        c  = DATA_WIDTH'(q0)
           + (DATA_WIDTH'(q1) << 2)
           + (DATA_WIDTH'(q2) << 2)
           + (DATA_WIDTH'(q3) << 4);
    end

endmodule

// File: rtl/vedic_mult_seq_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 vedic core, four nibble steps, valid/ready on both sides.
module vedic_mult_seq_ctrl
    import vedic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SUB_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH/2-1:0]   inData_A,
    input  logic [DATA_WIDTH/2-1:0]   inData_B,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     outData_C,
    output logic                      busy,
    output logic [7:0]                op_count
);

    state_t          state, state_nx;
    logic [1:0]      step, step_nx;
    logic [PRW-1:0]  acc, acc_nx;
    operand_t        ops, ops_nx;
    logic [7:0]      cnt_nx;
    logic            in_ready_nx, out_valid_nx, busy_nx;

    logic [NIBW-1:0] nib_a_c, nib_b_c;
    logic [OPW-1:0]  pp_c;
    logic [3:0]      sh_c;
    logic [PRW-1:0]  pp_sh_c;

    // step[0] picks the A nibble, step[1] the B nibble
    always_comb begin
        nib_a_c = step[0] ? ops.a[7:4] : ops.a[3:0];
        nib_b_c = step[1] ? ops.b[7:4] : ops.b[3:0];
        case (step)
            2'd0:    sh_c = 4'(SH0);
            2'd1:    sh_c = 4'(SH1);
            2'd2:    sh_c = 4'(SH2);
            default: sh_c = 4'(SH3);
        endcase
        pp_sh_c = PRW'(pp_c) << sh_c;
    end

    vedicmultiplier_4bit #(
        .DATA_WIDTH (SUB_WIDTH)
    ) u_vm4 (
        .a (nib_a_c),
        .b (nib_b_c),
        .c (pp_c)
    );

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nx     = state;
        step_nx      = step;
        acc_nx       = acc;
        ops_nx       = ops;
        cnt_nx       = op_count;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    ops_nx   = '{a: inData_A, b: inData_B};
                    acc_nx   = '0;
                    step_nx  = 2'd0;
                    state_nx = MUL;
                end
            end
            MUL: begin
                acc_nx  = acc + pp_sh_c;
                step_nx = step + 2'd1;
                if (step == 2'd3) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    cnt_nx   = op_count + 8'd1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        in_ready_nx  = (state_nx == IDLE);
        out_valid_nx = (state_nx == DONE);
        busy_nx      = (state_nx == MUL) || (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 2'd0;
            acc       <= '0;
            ops       <= '0;
            op_count  <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            acc       <= acc_nx;
            ops       <= ops_nx;
            op_count  <= cnt_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
        end
    end

    assign outData_C = acc;

endmodule

// File: doc/vedic_mult_seq_ctrl.md
Name: vedic_mult_seq_ctrl

Overview:
Sequential 8x8 unsigned multiplier controller. It time-shares a single 4x4 vedic multiplier across four partial-product steps and accumulates them into a 16-bit product. Valid/ready handshakes on the input and output sides let it sit between an operand source and a result consumer in the 10x10/8-bit datapath. It is the area-reduced alternative to a fully parallel 8x8 vedic tree.

Parameters:
DATA_WIDTH, 16, product width; operand width is DATA_WIDTH/2 = 8. Only 16 is supported.
SUB_WIDTH, 8, DATA_WIDTH parameter passed to the shared 4x4 multiplier (4-bit operands, 8-bit product).

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
inData_A  input  8  operand A, unsigned
inData_B  input  8  operand B, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
outData_C  output  16  product A*B, unsigned
busy  output  1  high in MUL or DONE
op_count  output  8  completed-transfer counter, wraps 255->0

Behaviour:
- Reset (async assert, sync release): state=IDLE, step=0, acc=0, regA=regB=0, out_valid=0, outData_C=0, op_count=0, busy=0, in_ready=1 once rst_n=1.
- States: IDLE, MUL, DONE. 2-bit step counter is used only in MUL.
- IDLE: in_ready=1. If in_valid is high at a rising edge, capture inData_A/inData_B into regA/regB, clear acc to 0, set step=0, and go to MUL.
- MUL: in_ready=0. Each cycle, drive the shared multiplier with the nibble pair for the current step and add its 8-bit product, zero-extended and shifted, to acc:
  - step0: A[3:0]*B[3:0], shift 0
  - step1: A[7:4]*B[3:0], shift 4
  - step2: A[3:0]*B[7:4], shift 4
  - step3: A[7:4]*B[7:4], shift 8
- MUL transitions: step increments each cycle. At the step3 edge the final add completes and the state goes to DONE.
- The multiplier path is purely combinational from regA/regB/step. Nibble selection and shift are one mux level each.
- Latency: operands accepted at edge k give out_valid=1 after edge k+4. outData_C is driven directly from acc.
- DONE: out_valid=1, busy=1, in_ready=0. outData_C stays stable while out_ready=0 (backpressure, held indefinitely). When out_valid and out_ready are both high at an edge, go to IDLE and increment op_count. acc keeps its value, so outData_C retains the last product until the next accept.
- Throughput: at most one product per 6 cycles (accept, 4×MUL, DONE≥1). No overlap; in_ready is low throughout MUL and DONE.
- in_valid while not IDLE: ignored, operands not sampled. An upstream source must hold its data until in_ready.
- Width: acc is 16 bits and never overflows (max 0xFF*0xFF=0xFE01). Intermediate adds are 16 bits with no carry-out.
- rst_n asserted mid-MUL or in DONE: immediately return to reset values. The partial product is discarded and no out_valid pulse occurs.
- out_ready in IDLE/MUL: no effect.
- X-safety: out_valid, in_ready, and busy are never X after reset.

Decomposition:
- Shared package vedic_pkg: state localparams (IDLE=2'd0, MUL=2'd1, DONE=2'd2), step shift constants (SH0=0, SH1=4, SH2=4, SH3=8), and OPW=8 / PRW=16 width constants.
- One sub-module: instantiate the existing vedicmultiplier_4bit once with DATA_WIDTH=SUB_WIDTH. Nibble muxing, accumulation, and the FSM live in this block; no other new sub-modules.

Test Plan:
- Reset, then in_valid with A=0x12, B=0x34, out_ready=1 -> in_ready drops next cycle; out_valid high 4 cycles after accept; outData_C=0x03A8; op_count=1.
- A=0xFF, B=0xFF -> outData_C=0xFE01. A=0x0F, B=0xF0 -> 0x0E10. A=0xA5, B=0x00 -> 0x0000.
- Backpressure: A=0x07, B=0x09 with out_ready=0 for 10 cycles -> out_valid held, outData_C=0x003F stable, in_ready=0; raise out_ready -> one transfer, IDLE next cycle, op_count increments once.
- in_valid held high with changing data during MUL/DONE -> operands unchanged, result matches the originally accepted pair.
- rst_n pulsed low during step2 of A=0x80, B=0x80 -> out_valid never asserts, acc=0, in_ready=1 after release; next op A=0x80, B=0x80 -> 0x4000.
- 256 back-to-back transfers with in_valid=out_ready=1 -> op_count wraps to 0x00; 1000 random pairs match A*B against the scoreboard.
